regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the single RegisterFile write port (A3/WD/RegWrite) among NREQ writeback requesters
//   (ALU, load unit, multiplier). Uses round-robin arbitration with a per-requester valid/ready
//   handshake and drives a registered write command into RegisterFile. Publishes a one-hot
//   pending-write mask so read-side logic can detect a write landing in the current cycle.
// PARAMETERS
//   NREQ         3   number of writeback requesters (2..8)
//   AW           5   register address width (2**AW registers)
//   DW           32  register data width
//   ZERO_REG_RO  1   1: writes to register 0 are accepted but dropped (RegWrite kept 0)
// PORTS
//   CLK        in   1        clock; all state updates on the rising edge
//   RST        in   1        asynchronous reset, active-low
//   EN         in   1        global enable; 0 = no grants, no writes issued
//   req_valid  in   NREQ     requester i has a write pending
//   req_addr   in   NREQ*AW  destination register of requester i, at bits [i*AW +: AW]
//   req_data   in   NREQ*DW  write data of requester i, at bits [i*DW +: DW]
//   req_ready  out  NREQ     combinational one-hot grant; transfer = valid & ready
//   RegWrite   out  1        registered write strobe to RegisterFile
//   A3         out  AW       registered write address to RegisterFile
//   WD         out  DW       registered write data to RegisterFile
//   grant_id   out  clog2(NREQ)  registered index of the requester whose write is on A3/WD
//   pend_mask  out  2**AW    one-hot of A3 when RegWrite=1, else all-zero
// BEHAVIOUR
//   - Reset (RST=0, async): RegWrite=0, A3=0, WD=0, grant_id=0, rr_ptr=NREQ-1.
//     req_ready=0 while RST=0. Any in-flight write is discarded.
//   - Arbitration (combinational, EN=1): search req_valid starting at rr_ptr+1 (mod NREQ).
//     The first valid requester gets req_ready=1; all others get 0.
//     No valid requester or EN=0 -> req_ready all-zero.
//   - Handshake: a requester holds valid/addr/data stable until it sees ready.
//     Dropping valid before the grant is illegal and is flagged by a bench assertion.
//   - Transfer cycle k (valid & ready for requester g):
//     at edge k+1, A3=addr_g, WD=data_g, grant_id=g, rr_ptr=g.
//     RegWrite=1, except RegWrite=0 when ZERO_REG_RO=1 and addr_g=0.
//     RegisterFile stores the data at edge k+2, so the write latency is 2 edges from the transfer.
//   - No transfer in cycle k -> RegWrite=0 at edge k+1. A3, WD and grant_id hold their values.
//     rr_ptr holds.
//   - Throughput: 1 write per cycle. With all NREQ continuously valid, grants rotate
//     0,1,..,NREQ-1,0,.. and the worst-case wait is NREQ-1 cycles.
//   - Same-address conflicts: only one request is granted per cycle, so writes land in grant
//     order. No merging and no reordering within a requester.
//   - EN=0: no grants. RegWrite=0 at the next edge. Pointer and requests are preserved and
//     resume when EN returns to 1.
//   - Register-0 drop: the request still consumes a grant and advances rr_ptr.
//     pend_mask stays all-zero.
//   - pend_mask is decoded from registered A3/RegWrite (glitch-free, no extra latency).
//     Bit A3 is set exactly in the cycle RegWrite=1.
// TESTING
//   1. Reset: RST=0 with all req_valid=1
//      -> req_ready=0, RegWrite=0, A3=0, WD=0, pend_mask=0.
//      Release RST -> first grant goes to requester 0.
//   2. Single requester: req1 addr=5 data=10 for one cycle
//      -> ready1=1; next edge RegWrite=1, A3=5, WD=10, grant_id=1, pend_mask=1<<5.
//      RegisterFile reads 10 from reg 5 afterwards.
//   3. Round-robin: all 3 valid continuously (addr=i+1, data=i+100)
//      -> grant order 0,1,2,0,1,2, WD=100,101,102,... one per cycle, no gaps.
//   4. Conflict: req0 and req2 both addr=10, data 20/30, same cycle, rr_ptr=0
//      -> req2 granted first, then req0; reg 10 ends at 20.
//   5. Zero reg + EN: req0 addr=0 data=7 -> ready0=1, RegWrite stays 0, reg 0 unchanged.
//      EN=0 for 4 cycles with req1 valid -> no ready, RegWrite=0; EN=1 -> req1 granted.
//   6. Reset mid-op: assert RST between transfer and write edge
//      -> RegWrite=0 immediately, write lost; rr_ptr restarts at NREQ-1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single RegisterFile write port among NREQ writeback requesters
//   using round-robin arbitration with a valid/ready handshake per requester.
//   The winning request is registered onto RegWrite/A3/WD one edge after the
//   transfer.
// Ports
//   CLK        clock, rising edge
//   RST        asynchronous reset, active-low
//   EN         global enable; 0 blocks grants and writes
//   req_valid  per-requester write pending
//   req_addr   requester i address at [i*AW +: AW]
//   req_data   requester i data at [i*DW +: DW]
//   req_ready  combinational one-hot grant (transfer = valid & ready)
//   RegWrite   registered write strobe
//   A3, WD     registered write address / data
//   grant_id   registered index of the requester that owns A3/WD
//   pend_mask  one-hot of A3 while RegWrite=1, else zero
module regfile_wb_arbiter #(
  parameter int NREQ        = 3,
  parameter int AW          = 5,
  parameter int DW          = 32,
  parameter int ZERO_REG_RO = 1,
  localparam int GW         = $clog2(NREQ)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 RegWrite,
  output logic [AW-1:0]        A3,
  output logic [DW-1:0]        WD,
  output logic [GW-1:0]        grant_id,
  output logic [(2**AW)-1:0]   pend_mask
);

  localparam int unsigned N = NREQ;

  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] sel;
  logic          hit;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          drop;

  // Search starts one past the last winner so the last winner is checked last.
  always_comb begin
    int unsigned idx;
    hit = 1'b0;
    sel = '0;
    idx = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(rr_ptr) + i) % N;
      if (!hit && req_valid[idx]) begin
        hit = 1'b1;
        sel = GW'(idx);
      end
    end
    if (!EN || !RST) hit = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (hit) req_ready[sel] = 1'b1;
  end

  always_comb begin
    sel_addr = req_addr[int'(sel)*AW +: AW];
    sel_data = req_data[int'(sel)*DW +: DW];
    drop     = (ZERO_REG_RO != 0) && (sel_addr == '0);
  end

  // A dropped register-0 write still consumes the grant and moves the pointer.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RegWrite <= 1'b0;
      A3       <= '0;
      WD       <= '0;
      grant_id <= '0;
      rr_ptr   <= GW'(NREQ - 1);
    end else begin
      RegWrite <= hit && !drop;
      if (hit) begin
        A3       <= sel_addr;
        WD       <= sel_data;
        grant_id <= sel;
        rr_ptr   <= sel;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    if (RegWrite) pend_mask[A3] = 1'b1;
  end

endmodule
